// File: rtl/fp_hazard_ctrl.sv
// Issue/hazard controller for the FP ALU control pipeline: RAW scoreboard plus multiply stall.
// Optional macro FP_HAZ_BYPASS_EN drops the writeback-stage entry from hazard comparison (write-through regfile).
module fp_hazard_ctrl #(
    parameter int WB_DEPTH   = 4,
    parameter int REG_AW     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int EX_STAGE   = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              instValid,
    input  logic [REG_AW-1:0] srcA,
    input  logic [REG_AW-1:0] srcB,
    input  logic              srcAEn,
    input  logic              srcBEn,
    input  logic [REG_AW-1:0] dest,
    input  logic [REG_AW-1:0] dest2,
    input  logic              destWrEn,
    input  logic              dest2WrEn,
    input  logic              isMul,
    output logic              issue,
    output logic              holdFetch,
    output logic              stall,
    output logic [3:0]        mulBusy,
    output logic [15:0]       hazardCnt
);

`ifdef FP_HAZ_BYPASS_EN
    localparam int CMP_DEPTH = WB_DEPTH - 1;
`else
    localparam int CMP_DEPTH = WB_DEPTH;
`endif

    typedef struct packed {
        logic              vld;
        logic              wr;
        logic [REG_AW-1:0] addr;
        logic              wr2;
        logic [REG_AW-1:0] addr2;
        logic              mul;
    } sb_entry_t;

    sb_entry_t         sb [WB_DEPTH];
    sb_entry_t         new_entry;
    logic              raw_hit;
    logic              hazard;
    logic              mul_load;
    logic [3:0]        mul_busy_nxt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic src_hit(input sb_entry_t e, input logic [REG_AW-1:0] src);
        return e.vld && ((e.wr && (e.addr == src)) || (e.wr2 && (e.addr2 == src)));
    endfunction

    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < CMP_DEPTH; k++) begin
            if ((srcAEn && src_hit(sb[k], srcA)) || (srcBEn && src_hit(sb[k], srcB)))
                raw_hit = 1'b1;
        end
    end

    assign hazard    = instValid & raw_hit;
    assign issue     = instValid & ~hazard & ~stall;
    assign holdFetch = instValid & (hazard | stall);

    // A rejected instruction enters as a bubble so nothing stale can match later.
    always_comb begin
        new_entry       = '0;
        new_entry.vld   = issue;
        new_entry.wr    = issue & destWrEn;
        new_entry.addr  = dest;
        new_entry.wr2   = issue & dest2WrEn;
        new_entry.addr2 = dest2;
        new_entry.mul   = issue & isMul;
    end

    assign mul_load = ~stall & sb[EX_STAGE-2].vld & sb[EX_STAGE-2].mul;

    always_comb begin
        mul_busy_nxt = 4'd0;
        if (mul_load)
            mul_busy_nxt = 4'(MUL_CYCLES - 1);
        else if (mulBusy != 4'd0)
            mul_busy_nxt = mulBusy - 4'd1;
    end

    // Stage boundary: scoreboard shift, multiply countdown, hazard statistics.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < WB_DEPTH; k++)
                sb[k].vld <= 1'b0;
            mulBusy   <= 4'd0;
            stall     <= 1'b0;
            hazardCnt <= 16'd0;
        end else begin
            if (!stall) begin
                sb[0] <= new_entry;
                for (int k = 1; k < WB_DEPTH; k++)
                    sb[k] <= sb[k-1];
            end
            mulBusy <= mul_busy_nxt;
            stall   <= (mul_busy_nxt != 4'd0);
            if (hazard && !stall)
                hazardCnt <= sat_inc16(hazardCnt);
        end
    end

endmodule

// File: tb/tb_fp_hazard_ctrl.sv
// Self-checking bench for fp_hazard_ctrl: directed scenarios plus random traffic against an op-age model.
module tb_fp_hazard_ctrl;

    localparam int WB_DEPTH   = 4;
    localparam int REG_AW     = 4;
    localparam int MUL_CYCLES = 4;
    localparam int EX_STAGE   = 2;
`ifdef FP_HAZ_BYPASS_EN
    localparam int WIN = WB_DEPTH - 1;
`else
    localparam int WIN = WB_DEPTH;
`endif

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              instValid = 1'b0;
    logic [REG_AW-1:0] srcA = '0, srcB = '0, dest = '0, dest2 = '0;
    logic              srcAEn = 1'b0, srcBEn = 1'b0, destWrEn = 1'b0, dest2WrEn = 1'b0, isMul = 1'b0;
    logic              issue, holdFetch, stall;
    logic [3:0]        mulBusy;
    logic [15:0]       hazardCnt;

    fp_hazard_ctrl #(.WB_DEPTH(WB_DEPTH), .REG_AW(REG_AW), .MUL_CYCLES(MUL_CYCLES), .EX_STAGE(EX_STAGE)) dut (
        .Clock(Clock), .Reset(Reset), .instValid(instValid),
        .srcA(srcA), .srcB(srcB), .srcAEn(srcAEn), .srcBEn(srcBEn),
        .dest(dest), .dest2(dest2), .destWrEn(destWrEn), .dest2WrEn(dest2WrEn), .isMul(isMul),
        .issue(issue), .holdFetch(holdFetch), .stall(stall), .mulBusy(mulBusy), .hazardCnt(hazardCnt)
    );

    always #5 Clock = ~Clock;

    // Reference model: issued ops with their age in unstalled edges since issue.
    typedef struct {
        logic [REG_AW-1:0] a;
        logic              w;
        logic [REG_AW-1:0] a2;
        logic              w2;
        logic              mul;
        int                age;
    } op_t;

    op_t q[$];
    int  mb;
    int  hcnt;
    int  n_checks = 0;
    int  n_pass = 0;

    logic        obs_issue, obs_hold, obs_stall;
    logic [3:0]  obs_mb;
    logic [15:0] obs_hcnt;

    function automatic bit reads(input logic [REG_AW-1:0] r, input op_t o);
        return (o.w && o.a == r) || (o.w2 && o.a2 == r);
    endfunction

    function automatic bit model_hazard();
        if (!instValid) return 1'b0;
        foreach (q[i]) begin
            if (q[i].age <= WIN) begin
                if (srcAEn && reads(srcA, q[i])) return 1'b1;
                if (srcBEn && reads(srcB, q[i])) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_clear();
        q.delete();
        mb = 0;
        hcnt = 0;
    endfunction

    function automatic void model_edge(input bit hz, input bit stl, input bit iss);
        bit  trig;
        op_t keep[$];
        op_t n;
        if (Reset) begin
            model_clear();
            return;
        end
        if (hz && !stl && hcnt < 65535) hcnt++;
        if (stl) begin
            mb--;
        end else begin
            trig = 1'b0;
            foreach (q[i]) if (q[i].mul && q[i].age == EX_STAGE - 1) trig = 1'b1;
            foreach (q[i]) begin
                q[i].age++;
                if (q[i].age <= WB_DEPTH) keep.push_back(q[i]);
            end
            q = keep;
            if (iss) begin
                n.a = dest; n.w = destWrEn; n.a2 = dest2; n.w2 = dest2WrEn; n.mul = isMul; n.age = 1;
                q.push_back(n);
            end
            mb = trig ? MUL_CYCLES - 1 : 0;
        end
    endfunction

    task automatic cycle();
        bit m_hz, m_stl, m_iss, m_hold;
        @(negedge Clock);
        obs_issue = issue; obs_hold = holdFetch; obs_stall = stall; obs_mb = mulBusy; obs_hcnt = hazardCnt;
        m_hz   = model_hazard();
        m_stl  = (mb != 0);
        m_iss  = instValid && !m_hz && !m_stl;
        m_hold = instValid && (m_hz || m_stl);
        n_checks++;
        if (obs_issue !== m_iss) $display("FAIL issue t=%0t got %b exp %b", $time, obs_issue, m_iss);
        else n_pass++;
        n_checks++;
        if (obs_hold !== m_hold) $display("FAIL holdFetch t=%0t got %b exp %b", $time, obs_hold, m_hold);
        else n_pass++;
        n_checks++;
        if (obs_stall !== m_stl) $display("FAIL stall t=%0t got %b exp %b", $time, obs_stall, m_stl);
        else n_pass++;
        n_checks++;
        if (obs_mb !== 4'(mb)) $display("FAIL mulBusy t=%0t got %0d exp %0d", $time, obs_mb, mb);
        else n_pass++;
        n_checks++;
        if (obs_hcnt !== 16'(hcnt)) $display("FAIL hazardCnt t=%0t got %0d exp %0d", $time, obs_hcnt, hcnt);
        else n_pass++;
        model_edge(m_hz, m_stl, m_iss);
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [REG_AW-1:0] a, input logic aen,
                            input logic [REG_AW-1:0] b, input logic ben,
                            input logic [REG_AW-1:0] d, input logic dwe,
                            input logic [REG_AW-1:0] d2, input logic d2we, input logic mul);
        instValid = v; srcA = a; srcAEn = aen; srcB = b; srcBEn = ben;
        dest = d; destWrEn = dwe; dest2 = d2; dest2WrEn = d2we; isMul = mul;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive_op(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_clear();
        cycle();
        n_checks++;
        if (obs_issue !== 1'b1) $display("FAIL reset_issue got %b exp 1", obs_issue); else n_pass++;
        n_checks++;
        if (obs_hold !== 1'b0) $display("FAIL reset_hold got %b exp 0", obs_hold); else n_pass++;
        n_checks++;
        if (obs_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", obs_stall); else n_pass++;
        n_checks++;
        if (obs_mb !== 4'd0) $display("FAIL reset_mulBusy got %0d exp 0", obs_mb); else n_pass++;
        n_checks++;
        if (obs_hcnt !== 16'd0) $display("FAIL reset_hazardCnt got %0d exp 0", obs_hcnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_op(1, 4'(9 + i % 7), 1, 4'(9 + (i + 3) % 7), 1, 4'(1 + i), 1, 0, 0, 0);
            cycle();
            if (obs_issue === 1'b1) issued++;
        end
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        n_checks++;
        if (issued != 8) $display("FAIL b2b_issued got %0d exp 8", issued); else n_pass++;
        n_checks++;
        if (obs_hcnt !== 16'd0) $display("FAIL b2b_hazardCnt got %0d exp 0", obs_hcnt); else n_pass++;
    endtask

    task automatic test_raw(input bit use_dest2);
        int issued_at = -1;
        int holds = 0;
        logic [15:0] cnt_at_issue = 16'hDEAD;
        do_reset();
        if (use_dest2) drive_op(1, 0, 0, 0, 0, 4'd1, 1, 4'd7, 1, 0);
        else           drive_op(1, 0, 0, 0, 0, 4'd3, 1, 4'd0, 0, 0);
        cycle();
        if (use_dest2) drive_op(1, 4'd9, 1, 4'd7, 1, 4'd10, 1, 0, 0, 0);
        else           drive_op(1, 4'd3, 1, 4'd9, 1, 4'd10, 1, 0, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (obs_hold === 1'b1) holds++;
            if (obs_issue === 1'b1) begin
                issued_at = c;
                cnt_at_issue = obs_hcnt;
                break;
            end
        end
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (issued_at != WIN + 1) $display("FAIL raw%0d_issue_cycle got %0d exp %0d", use_dest2, issued_at, WIN + 1);
        else n_pass++;
        n_checks++;
        if (holds != WIN) $display("FAIL raw%0d_hold_cycles got %0d exp %0d", use_dest2, holds, WIN);
        else n_pass++;
        n_checks++;
        if (cnt_at_issue !== 16'(WIN)) $display("FAIL raw%0d_hazardCnt got %0d exp %0d", use_dest2, cnt_at_issue, WIN);
        else n_pass++;
    endtask

    task automatic test_mul();
        int idx = 0;
        bit e_st;
        int e_mb;
        do_reset();
        drive_op(1, 4'd9, 1, 4'd10, 1, 4'd1, 1, 0, 0, 1);
        cycle();
        for (int k = 1; k <= 7; k++) begin
            drive_op(1, 4'd9, 1, 4'd10, 1, 4'(2 + idx), 1, 0, 0, 0);
            cycle();
            e_st = (k >= 2 && k <= 4);
            e_mb = e_st ? 5 - k : 0;
            n_checks++;
            if (obs_stall !== e_st) $display("FAIL mul_stall c%0d got %b exp %b", k, obs_stall, e_st); else n_pass++;
            n_checks++;
            if (obs_mb !== 4'(e_mb)) $display("FAIL mul_busy c%0d got %0d exp %0d", k, obs_mb, e_mb); else n_pass++;
            n_checks++;
            if (obs_issue !== !e_st) $display("FAIL mul_issue c%0d got %b exp %b", k, obs_issue, !e_st); else n_pass++;
            if (obs_issue === 1'b1) idx++;
        end
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_op(1, 0, 0, 0, 0, 4'd3, 1, 0, 0, 1);
        cycle();
        drive_op(1, 4'd3, 1, 4'd9, 0, 4'd5, 1, 0, 0, 0);
        cycle();
        cycle();
        Reset = 1'b1;
        cycle();
        n_checks++;
        if (obs_stall !== 1'b1) $display("FAIL mid_pre_stall got %b exp 1", obs_stall); else n_pass++;
        Reset = 1'b0;
        cycle();
        n_checks++;
        if (obs_stall !== 1'b0) $display("FAIL mid_stall got %b exp 0", obs_stall); else n_pass++;
        n_checks++;
        if (obs_mb !== 4'd0) $display("FAIL mid_mulBusy got %0d exp 0", obs_mb); else n_pass++;
        n_checks++;
        if (obs_hcnt !== 16'd0) $display("FAIL mid_hazardCnt got %0d exp 0", obs_hcnt); else n_pass++;
        n_checks++;
        if (obs_issue !== 1'b1) $display("FAIL mid_issue got %b exp 1", obs_issue); else n_pass++;
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        bit take_new = 1'b1;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (take_new) begin
                drive_op(($urandom % 5) != 0,
                         4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom),
                         4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)), ($urandom % 4) == 0,
                         ($urandom % 10) == 0);
            end
            Reset = (($urandom % 150) == 0);
            cycle();
            take_new = (obs_issue === 1'b1) || !instValid || Reset;
        end
        Reset = 1'b0;
        drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_raw(1'b0);
        test_raw(1'b1);
        test_mul();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
